ddr3_rw_arbiter: RTL and testbench
==================================

Name: ddr3_rw_arbiter

Overview:
- Shares the DDR3 memory-controller user interface between two requesters, clocked on the controller's user clock.
- Write port (W): the SD/WAV loader stores sample blocks.
- Read port (R): the audio playback prefetch fetches sample blocks.
- Each request is one 256-bit single-beat transfer. The block sequences cmd/cmd_en, the write-data handshake and read-return capture, and flags reads that never return.

Parameters:
- ADDR_WIDTH, 29, DDR user address width.
- DATA_WIDTH, 256, user data width; mask width = DATA_WIDTH/8.
- RD_TIMEOUT, 1023, cycles to wait for rd_data_valid before aborting a read.

Ports:
- clk  in  1  controller user clock (clk_out of DDR3 IP)
- rst  in  1  synchronous reset, active-high
- init_calib_complete  in  1  DDR ready; no command is issued while low
- w_req  in  1  write request; held with w_addr/w_data until w_ack
- w_addr  in  ADDR_WIDTH  write address
- w_data  in  DATA_WIDTH  write data
- w_ack  out  1  one-cycle pulse: command and data both accepted
- r_req  in  1  read request; held with r_addr until r_ack
- r_addr  in  ADDR_WIDTH  read address
- r_ack  out  1  one-cycle pulse: read command accepted
- r_valid  out  1  one-cycle pulse: r_data valid
- r_data  out  DATA_WIDTH  registered read data
- rd_timeout_err  out  1  sticky; set on read timeout, cleared only by rst
- cmd  out  3  3'b000 write, 3'b001 read
- cmd_en  out  1  command strobe
- cmd_ready  in  1  controller accepts cmd when cmd_en&cmd_ready
- addr  out  ADDR_WIDTH  command address
- wr_data  out  DATA_WIDTH  write data
- wr_data_en  out  1  write data strobe
- wr_data_end  out  1  equals wr_data_en (single beat)
- wr_data_mask  out  DATA_WIDTH/8  always 0 (all bytes written)
- wr_data_rdy  in  1  controller accepts data when wr_data_en&wr_data_rdy
- rd_data  in  DATA_WIDTH  controller read data
- rd_data_valid  in  1  controller read data valid

Behaviour:
- Reset values: every output 0, including cmd=3'b000. State=IDLE, last_grant=R, timeout counter=0.
- FSM states are IDLE, WR, RD_CMD and RD_WAIT.
- IDLE:
  - No action while init_calib_complete=0.
  - Otherwise arbitrate round-robin. If only one request is present, grant it. If both are present, grant the side opposite last_grant.
  - Latch the granted addr/data into output registers. Update last_grant. Move to WR or RD_CMD on the next cycle.
- WR:
  - Drive cmd=000, cmd_en=1, wr_data_en=wr_data_end=1.
  - Two independent done flags:
    - cmd_done sets and cmd_en drops on cmd_en&cmd_ready.
    - data_done sets and wr_data_en drops on wr_data_en&wr_data_rdy.
  - Both handshakes may complete in the same cycle, and in either order.
  - When both are done, pulse w_ack for 1 cycle, clear the flags and return to IDLE.
- RD_CMD:
  - Drive cmd=001, cmd_en=1.
  - On cmd_ready: drop cmd_en, pulse r_ack, clear the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - On rd_data_valid: register r_data<=rd_data, pulse r_valid next cycle, go to IDLE.
  - Counter increments each cycle. On reaching RD_TIMEOUT: set rd_timeout_err, go to IDLE, no r_valid.
  - rd_data_valid arriving in any other state is ignored.
- Latency:
  - Request to cmd_en is 1 cycle.
  - rd_data_valid to r_valid is 1 cycle.
  - Minimum write turnaround is 3 cycles (IDLE, WR with both ready, IDLE).
- Boundary rules:
  - Requesters must not change addr/data between req and ack.
  - A requester dropping req before ack leaves the operation unaffected, since payload is already latched.
  - Only one operation is in flight; there is no pipelining.
  - init_calib_complete falling mid-operation does not abort the current operation; it blocks new grants only.
  - rst mid-operation immediately returns to IDLE with all strobes low.

Optional Feature:
- Macro: DDR3_ARB_READ_PRIORITY_EN.
- When defined: if r_req and w_req are both present in IDLE, R always wins (protects playback from underrun). last_grant is ignored.
- When undefined: round-robin as above.

Test Plan:
- Reset and calibration gate: hold init_calib_complete=0 with w_req=1 and r_req=1 for 20 cycles -> cmd_en, wr_data_en, w_ack and r_ack all stay 0. Raise init_calib_complete -> cmd_en asserts next cycle.
- Write, independent readies: w_addr=0x100, w_data=0xA5.., wr_data_rdy high 3 cycles before cmd_ready -> wr_data_en drops after the data handshake. cmd_en holds until cmd_ready. Single w_ack pulse, addr=0x100, cmd=000, wr_data_mask=0.
- Read return: r_addr=0x200, cmd_ready immediate, rd_data_valid 12 cycles later with 0x1234.. -> r_ack pulses once, r_valid pulses one cycle after rd_data_valid, r_data=0x1234...
- Contention: w_req and r_req held continuously for 4 operations, after reset -> grant order W,R,W,R. With DDR3_ARB_READ_PRIORITY_EN defined -> R,R,R,R while r_req held.
- Timeout: read accepted, rd_data_valid never asserted -> rd_timeout_err=1 after 1023 cycles, FSM returns to IDLE, next w_req is serviced, no r_valid.
- Reset mid-write: assert rst while in WR with cmd_ready=0 -> cmd_en and wr_data_en=0 the following cycle, no w_ack.

Source files
------------

// File: rtl/ddr3_rw_arbiter.sv
// Shares the DDR3 controller user interface between the sample loader (write) and playback prefetch (read).
// Define DDR3_ARB_READ_PRIORITY_EN to make reads always win contention instead of round-robin.
module ddr3_rw_arbiter #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_calib_complete,
  input  logic                    w_req,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_ack,
  input  logic                    r_req,
  input  logic [ADDR_WIDTH-1:0]   r_addr,
  output logic                    r_ack,
  output logic                    r_valid,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    rd_timeout_err,
  output logic [2:0]              cmd,
  output logic                    cmd_en,
  input  logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_data_en,
  output logic                    wr_data_end,
  output logic [DATA_WIDTH/8-1:0] wr_data_mask,
  input  logic                    wr_data_rdy,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_data_valid
);

  localparam int CNT_WIDTH = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RD_TIMEOUT - 1);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

  state_t               r_state;
  logic                 r_lastGrantRd;
  logic                 r_cmdDone;
  logic                 r_dataDone;
  logic [CNT_WIDTH-1:0] r_timeoutCnt;

  logic w_wReqLive;
  logic w_grantWr;
  logic w_cmdHs;
  logic w_dataHs;
  logic w_cmdDoneNext;
  logic w_dataDoneNext;

  // A registered requester still shows w_req in the cycle w_ack is high; masking it prevents a duplicate write.
  assign w_wReqLive = w_req & ~w_ack;

`ifdef DDR3_ARB_READ_PRIORITY_EN
  assign w_grantWr = w_wReqLive & ~r_req;
`else
  assign w_grantWr = w_wReqLive & (~r_req | r_lastGrantRd);
`endif

  assign w_cmdHs        = cmd_en & cmd_ready;
  assign w_dataHs       = wr_data_en & wr_data_rdy;
  assign w_cmdDoneNext  = r_cmdDone | w_cmdHs;
  assign w_dataDoneNext = r_dataDone | w_dataHs;

  assign wr_data_end  = wr_data_en;
  assign wr_data_mask = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_lastGrantRd  <= 1'b1;
      r_cmdDone      <= 1'b0;
      r_dataDone     <= 1'b0;
      r_timeoutCnt   <= '0;
      w_ack          <= 1'b0;
      r_ack          <= 1'b0;
      r_valid        <= 1'b0;
      r_data         <= '0;
      rd_timeout_err <= 1'b0;
      cmd            <= CMD_WRITE;
      cmd_en         <= 1'b0;
      addr           <= '0;
      wr_data        <= '0;
      wr_data_en     <= 1'b0;
    end else begin
      w_ack   <= 1'b0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init_calib_complete) begin
            if (w_grantWr) begin
              addr          <= w_addr;
              wr_data       <= w_data;
              cmd           <= CMD_WRITE;
              cmd_en        <= 1'b1;
              wr_data_en    <= 1'b1;
              r_cmdDone     <= 1'b0;
              r_dataDone    <= 1'b0;
              r_lastGrantRd <= 1'b0;
              r_state       <= WR;
            end else if (r_req) begin
              addr          <= r_addr;
              cmd           <= CMD_READ;
              cmd_en        <= 1'b1;
              r_lastGrantRd <= 1'b1;
              r_state       <= RD_CMD;
            end
          end
        end
        // Command and data handshakes are independent and may land in either order or together.
        WR: begin
          if (w_cmdHs) cmd_en <= 1'b0;
          if (w_dataHs) wr_data_en <= 1'b0;
          if (w_cmdDoneNext && w_dataDoneNext) begin
            w_ack      <= 1'b1;
            r_cmdDone  <= 1'b0;
            r_dataDone <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_cmdDone  <= w_cmdDoneNext;
            r_dataDone <= w_dataDoneNext;
          end
        end
        RD_CMD: begin
          if (cmd_ready) begin
            cmd_en       <= 1'b0;
            r_ack        <= 1'b1;
            r_timeoutCnt <= '0;
            r_state      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_data_valid) begin
            r_data  <= rd_data;
            r_valid <= 1'b1;
            r_state <= IDLE;
          end else if (r_timeoutCnt == CNT_LAST) begin
            rd_timeout_err <= 1'b1;
            r_state        <= IDLE;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + CNT_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Scoreboard bench for ddr3_rw_arbiter: a mock DDR3 controller, a high-level memory/arbitration model
// and a negedge monitor that pops expected commands, write data and read returns.
module tb_ddr3_rw_arbiter;

  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic          isRead;
    logic [AW-1:0] addr;
  } cmdExp_t;

  logic          clk;
  logic          rst;
  logic          initCalib;
  logic          wReq;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic          wAck;
  logic          rReq;
  logic [AW-1:0] rAddr;
  logic          rAck;
  logic          rValid;
  logic [DW-1:0] rDataOut;
  logic          rdTimeoutErr;
  logic [2:0]    cmdOut;
  logic          cmdEn;
  logic          cmdReady;
  logic [AW-1:0] addrOut;
  logic [DW-1:0] wrDataOut;
  logic          wrDataEn;
  logic          wrDataEnd;
  logic [MW-1:0] wrDataMask;
  logic          wrDataRdy;
  logic [DW-1:0] rdData;
  logic          rdDataValid;

  logic mockAuto;
  logic mockCmdReady;
  logic mockWrDataRdy;
  logic manCmdReady;
  logic manWrDataRdy;
  bit   rdSuppress;
  int   fixedLatency;

  int total = 0;
  int bad   = 0;

  cmdExp_t       cmdQ[$];
  logic [DW-1:0] wrQ[$];
  logic [DW-1:0] rdQ[$];
  logic [DW-1:0] modelMem[logic [AW-1:0]];
  logic [DW-1:0] mockMem[logic [AW-1:0]];

  assign cmdReady  = mockAuto ? mockCmdReady : manCmdReady;
  assign wrDataRdy = mockAuto ? mockWrDataRdy : manWrDataRdy;

  ddr3_rw_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (initCalib),
    .w_req               (wReq),
    .w_addr              (wAddr),
    .w_data              (wData),
    .w_ack               (wAck),
    .r_req               (rReq),
    .r_addr              (rAddr),
    .r_ack               (rAck),
    .r_valid             (rValid),
    .r_data              (rDataOut),
    .rd_timeout_err      (rdTimeoutErr),
    .cmd                 (cmdOut),
    .cmd_en              (cmdEn),
    .cmd_ready           (cmdReady),
    .addr                (addrOut),
    .wr_data             (wrDataOut),
    .wr_data_en          (wrDataEn),
    .wr_data_end         (wrDataEnd),
    .wr_data_mask        (wrDataMask),
    .wr_data_rdy         (wrDataRdy),
    .rd_data             (rdData),
    .rd_data_valid       (rdDataValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached, required bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
    if (modelMem.exists(a)) return modelMem[a];
    return '0;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string actualDesc, input string requiredDesc);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %s required %s", name, actualDesc, requiredDesc);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCmd(input logic isRead, input logic [AW-1:0] a);
    cmdExp_t e;
    e.isRead = isRead;
    e.addr   = a;
    cmdQ.push_back(e);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    pushCmd(1'b0, a);
    wrQ.push_back(d);
    modelMem[a] = d;
    wAddr = a;
    wData = d;
    wReq  = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!wAck && n < 500);
    if (!wAck) failNow("w_ack wait", "no w_ack in 500 cycles", "w_ack");
    wReq = 1'b0;
    cyc();
    checkOutput("w_ack pulse width", DW'(wAck), '0);
  endtask

  task automatic doRead(input logic [AW-1:0] a, input bit expectReturn);
    int n;
    pushCmd(1'b1, a);
    if (expectReturn) rdQ.push_back(modelRead(a));
    rAddr = a;
    rReq  = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!rAck && n < 500);
    if (!rAck) failNow("r_ack wait", "no r_ack in 500 cycles", "r_ack");
    rReq = 1'b0;
    cyc();
    checkOutput("r_ack pulse width", DW'(rAck), '0);
  endtask

  task automatic applyStimulus(input bit isRead, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (isRead) doRead(a, 1'b1);
    else doWrite(a, d);
  endtask

  task automatic waitDrain(input int limit);
    int n;
    int left;
    n = 0;
    while ((cmdQ.size() + wrQ.size() + rdQ.size()) != 0 && n < limit) begin
      cyc();
      n++;
    end
    left = cmdQ.size() + wrQ.size() + rdQ.size();
    checkOutput("scoreboard drained", DW'(left), '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Mock controller: random readies in auto mode, memory backed by observed write handshakes.
  initial begin
    int            countdown;
    bit            pending;
    logic [DW-1:0] pendData;
    pending       = 1'b0;
    countdown     = 0;
    pendData      = '0;
    mockCmdReady  = 1'b0;
    mockWrDataRdy = 1'b0;
    rdDataValid   = 1'b0;
    rdData        = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (cmdEn && cmdReady && cmdOut == 3'b001 && !rdSuppress) begin
          pending   = 1'b1;
          countdown = (fixedLatency > 0) ? fixedLatency : $urandom_range(1, 20);
          pendData  = mockMem.exists(addrOut) ? mockMem[addrOut] : '0;
        end
        if (wrDataEn && wrDataRdy) mockMem[addrOut] = wrDataOut;
      end
      @(posedge clk);
      #1;
      rdDataValid = 1'b0;
      rdData      = randData();
      if (pending) begin
        countdown--;
        if (countdown <= 0) begin
          rdDataValid = 1'b1;
          rdData      = pendData;
          pending     = 1'b0;
        end
      end
      mockCmdReady  = 1'($urandom_range(0, 1));
      mockWrDataRdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every DUT handshake or return pops the next expected item.
  initial begin
    cmdExp_t e;
    bit      prevRdv;
    prevRdv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmdEn && cmdReady) begin
          if (cmdQ.size() == 0) begin
            failNow("unexpected command", "cmd handshake", "none queued");
          end else begin
            e = cmdQ.pop_front();
            checkOutput("cmd opcode", DW'(cmdOut), DW'(e.isRead ? 3'b001 : 3'b000));
            checkOutput("cmd addr", DW'(addrOut), DW'(e.addr));
          end
        end
        if (wrDataEn && wrDataRdy) begin
          if (wrQ.size() == 0) begin
            failNow("unexpected write data", "data handshake", "none queued");
          end else begin
            checkOutput("wr_data", wrDataOut, wrQ.pop_front());
            checkOutput("wr_data_end", DW'(wrDataEnd), DW'(1));
            checkOutput("wr_data_mask", DW'(wrDataMask), '0);
          end
        end
        if (rValid) begin
          checkOutput("r_valid latency", DW'(prevRdv), DW'(1));
          if (rdQ.size() == 0) failNow("unexpected r_valid", "r_valid", "no read outstanding");
          else checkOutput("r_data", rDataOut, rdQ.pop_front());
        end
      end
      prevRdv = rdDataValid;
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] pool[8];
    logic [AW-1:0] cwAddr[2];
    logic [DW-1:0] cwData[2];
    logic [AW-1:0] crAddr[4];
    bit            activity;
    bit            lastR;
    bit            pickW;
    int            pw;
    int            pr;
    int            n;

    rst          = 1'b1;
    initCalib    = 1'b0;
    wReq         = 1'b0;
    rReq         = 1'b0;
    wAddr        = '0;
    wData        = '0;
    rAddr        = '0;
    mockAuto     = 1'b0;
    manCmdReady  = 1'b0;
    manWrDataRdy = 1'b0;
    rdSuppress   = 1'b0;
    fixedLatency = 0;
    cyc();
    cyc();
    cyc();

    checkOutput("reset cmd_en", DW'(cmdEn), '0);
    checkOutput("reset wr_data_en", DW'(wrDataEn), '0);
    checkOutput("reset wr_data_end", DW'(wrDataEnd), '0);
    checkOutput("reset w_ack", DW'(wAck), '0);
    checkOutput("reset r_ack", DW'(rAck), '0);
    checkOutput("reset r_valid", DW'(rValid), '0);
    checkOutput("reset rd_timeout_err", DW'(rdTimeoutErr), '0);
    checkOutput("reset cmd", DW'(cmdOut), '0);
    checkOutput("reset addr", DW'(addrOut), '0);
    checkOutput("reset wr_data", wrDataOut, '0);
    checkOutput("reset r_data", rDataOut, '0);
    rst = 1'b0;

    // Calibration gate, then write wins (last grant is R after reset); the dropped read is never issued.
    d = {16{16'h1234}};
    pushCmd(1'b0, 29'h200);
    wrQ.push_back(d);
    modelMem[29'h200] = d;
    wAddr = 29'h200;
    wData = d;
    rAddr = 29'h80;
    wReq  = 1'b1;
    rReq  = 1'b1;
    activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      activity |= cmdEn | wrDataEn | wAck | rAck;
    end
    checkOutput("calib gate activity", DW'(activity), '0);
    initCalib = 1'b1;
    cyc();
    checkOutput("calib cmd_en latency", DW'(cmdEn), DW'(1));
    wReq = 1'b0;
    rReq = 1'b0;
    manCmdReady  = 1'b1;
    manWrDataRdy = 1'b1;
    cyc();
    checkOutput("calib write w_ack", DW'(wAck), DW'(1));
    manCmdReady  = 1'b0;
    manWrDataRdy = 1'b0;
    cyc();
    cyc();
    checkOutput("dropped read not issued", DW'(cmdEn), '0);

    // Data handshake lands first, command several cycles later.
    d = {32{8'hA5}};
    pushCmd(1'b0, 29'h100);
    wrQ.push_back(d);
    modelMem[29'h100] = d;
    wAddr = 29'h100;
    wData = d;
    wReq  = 1'b1;
    manWrDataRdy = 1'b1;
    cyc();
    checkOutput("wr cmd_en asserted", DW'(cmdEn), DW'(1));
    checkOutput("wr wr_data_en asserted", DW'(wrDataEn), DW'(1));
    cyc();
    checkOutput("wr data dropped after handshake", DW'(wrDataEn), '0);
    checkOutput("wr cmd_en held", DW'(cmdEn), DW'(1));
    cyc();
    cyc();
    checkOutput("wr no early w_ack", DW'(wAck), '0);
    checkOutput("wr cmd_en still held", DW'(cmdEn), DW'(1));
    checkOutput("wr data stays low", DW'(wrDataEn), '0);
    manCmdReady = 1'b1;
    cyc();
    checkOutput("wr w_ack", DW'(wAck), DW'(1));
    checkOutput("wr cmd_en dropped", DW'(cmdEn), '0);
    wReq = 1'b0;
    manCmdReady  = 1'b0;
    manWrDataRdy = 1'b0;
    cyc();
    checkOutput("wr w_ack single pulse", DW'(wAck), '0);

    // Read return with immediate cmd_ready and a fixed 12-cycle controller latency.
    manCmdReady  = 1'b1;
    fixedLatency = 12;
    applyStimulus(1'b1, 29'h200, '0);
    waitDrain(100);
    fixedLatency = 0;

    // Read that never returns.
    rdSuppress = 1'b1;
    doRead(29'h200, 1'b0);
    n = 1;
    while (!rdTimeoutErr && n < 1200) begin
      cyc();
      n++;
    end
    checkOutput("timeout err set", DW'(rdTimeoutErr), DW'(1));
    checkOutput("timeout cycle count", DW'(n), DW'(1023));
    rdSuppress  = 1'b0;
    manCmdReady = 1'b0;
    mockAuto    = 1'b1;
    applyStimulus(1'b0, 29'h300, randData());
    waitDrain(200);
    checkOutput("timeout err sticky", DW'(rdTimeoutErr), DW'(1));

    // Reset in the middle of a write that the controller never accepts.
    mockAuto = 1'b0;
    wAddr = 29'h340;
    wData = randData();
    wReq  = 1'b1;
    cyc();
    checkOutput("midrst cmd_en before reset", DW'(cmdEn), DW'(1));
    rst = 1'b1;
    cyc();
    checkOutput("midrst cmd_en", DW'(cmdEn), '0);
    checkOutput("midrst wr_data_en", DW'(wrDataEn), '0);
    wReq = 1'b0;
    rst  = 1'b0;
    activity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      activity |= wAck;
    end
    checkOutput("midrst no w_ack", DW'(activity), '0);
    checkOutput("rst clears timeout err", DW'(rdTimeoutErr), '0);

    // Contention: both sides held; expected order comes from the grant rule applied to request counts.
    mockAuto = 1'b1;
    cwAddr = '{29'h400, 29'h440};
    cwData = '{randData(), randData()};
    crAddr = '{29'h400, 29'h440, 29'h200, 29'h400};
    applyStimulus(1'b0, 29'h400, randData());
    applyStimulus(1'b0, 29'h440, randData());
    waitDrain(200);
    doReset();
    pw = 0;
    pr = 0;
    lastR = 1'b1;
    while (pw < 2 || pr < 4) begin
`ifdef DDR3_ARB_READ_PRIORITY_EN
      pickW = (pw < 2) && !(pr < 4);
`else
      pickW = (pw < 2) && (!(pr < 4) || lastR);
`endif
      if (pickW) begin
        pushCmd(1'b0, cwAddr[pw]);
        wrQ.push_back(cwData[pw]);
        modelMem[cwAddr[pw]] = cwData[pw];
        pw++;
      end else begin
        pushCmd(1'b1, crAddr[pr]);
        rdQ.push_back(modelRead(crAddr[pr]));
        pr++;
      end
      lastR = !pickW;
    end
    fork
      begin
        int wn;
        for (int k = 0; k < 2; k++) begin
          wAddr = cwAddr[k];
          wData = cwData[k];
          wReq  = 1'b1;
          wn = 0;
          do begin cyc(); wn++; end while (!wAck && wn < 3000);
          if (!wAck) failNow("contention w_ack wait", "no w_ack", "w_ack");
        end
        wReq = 1'b0;
      end
      begin
        int rn;
        for (int k = 0; k < 4; k++) begin
          rAddr = crAddr[k];
          rReq  = 1'b1;
          rn = 0;
          do begin cyc(); rn++; end while (!rAck && rn < 3000);
          if (!rAck) failNow("contention r_ack wait", "no r_ack", "r_ack");
        end
        rReq = 1'b0;
      end
    join
    waitDrain(500);

    // Randomized single-requester traffic with random readies and read latency.
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'(32'h1000 + i * 32'h20);
      applyStimulus(1'b0, pool[i], randData());
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], randData());
    end
    waitDrain(3000);
    checkOutput("no spurious timeout", DW'(rdTimeoutErr), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
